// File: rtl/pe_row_cfg_seq.sv
// pe_row_cfg_seq: mask-driven config loader and run sequencer for one PE row (LSU + NUM_PE PEs)
// Ports: clk/rst (sync, active-low); cfg_start, cfg_mask, run_len, run_stop control a sequence;
// cfg_valid/cfg_ready/cfg_data carry per-slot words; PE_config, init_sel, init_en, run drive the row;
// busy, done, aborted report status. Slot bit NUM_PE = LSU, bit NUM_PE-1-i = PE_i.
module pe_row_cfg_seq #(
    parameter int NUM_PE = 4,
    parameter int INST_W = 32,
    parameter int RUN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic [NUM_PE:0]   cfg_mask,
    input  logic [RUN_W-1:0]  run_len,
    input  logic              run_stop,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [INST_W-1:0] cfg_data,
    output logic [INST_W-1:0] PE_config,
    output logic [NUM_PE:0]   init_sel,
    output logic              init_en,
    output logic              run,
    output logic              busy,
    output logic              done,
    output logic              aborted
);
    typedef enum logic [2:0] {IDLE, LOAD, GAP, RUN, DONE} state_t;
    state_t state;
    logic [NUM_PE:0] rem, pick, rem_next;
    logic [RUN_W-1:0] len, cnt, cnt_inc;
    // LSU sits in the top bit and PE_0 next, so the next slot is the highest remaining mask bit
    always_comb begin
        pick = '0;
        for (int i = 0; i <= NUM_PE; i++)
            if (rem[i]) begin
                pick = '0;
                pick[i] = 1'b1;
            end
    end
    assign rem_next = rem & ~pick;
    assign cnt_inc = cnt + RUN_W'(1);
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            rem <= '0;
            len <= '0;
            cnt <= '0;
            PE_config <= '0;
            init_sel <= '0;
            init_en <= 1'b0;
            cfg_ready <= 1'b0;
            run <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            aborted <= 1'b0;
        end else begin
            init_sel <= '0;
            init_en <= 1'b0;
            done <= 1'b0;
            aborted <= 1'b0;
            case (state)
                IDLE: if (cfg_start) begin
                    rem <= cfg_mask;
                    len <= run_len;
                    cnt <= '0;
                    busy <= 1'b1;
                    cfg_ready <= |cfg_mask;
                    run <= ~|cfg_mask;
                    state <= |cfg_mask ? LOAD : RUN;
                end
                LOAD, GAP: if (run_stop) begin
                    // abort wins over a same-cycle transfer, which is dropped
                    state <= IDLE;
                    rem <= '0;
                    busy <= 1'b0;
                    cfg_ready <= 1'b0;
                    aborted <= 1'b1;
                end else if (state == GAP) begin
                    state <= RUN;
                    run <= 1'b1;
                end else if (cfg_valid) begin
                    PE_config <= cfg_data;
                    init_sel <= pick;
                    init_en <= 1'b1;
                    rem <= rem_next;
                    if (rem_next == '0) begin
                        state <= GAP;
                        cfg_ready <= 1'b0;
                    end
                end
                RUN: if (run_stop || (len != '0 && cnt_inc == len)) begin
                    state <= DONE;
                    run <= 1'b0;
                    done <= 1'b1;
                end else if (~&cnt) begin
                    cnt <= cnt_inc;
                end
                DONE: begin
                    state <= IDLE;
                    busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pe_row_cfg_seq.sv
// tb_pe_row_cfg_seq: directed self-checking bench for pe_row_cfg_seq
module tb_pe_row_cfg_seq;
    localparam int NUM_PE = 4;
    localparam int INST_W = 32;
    localparam int RUN_W  = 16;
    logic clk = 1'b0, rst = 1'b0, cfg_start = 1'b0, run_stop = 1'b0, cfg_valid = 1'b0;
    logic [NUM_PE:0] cfg_mask = '0;
    logic [RUN_W-1:0] run_len = '0;
    logic [INST_W-1:0] cfg_data = '0;
    logic cfg_ready, init_en, run, busy, done, aborted;
    logic [INST_W-1:0] PE_config;
    logic [NUM_PE:0] init_sel;
    int checks = 0, errors = 0;
    int runs, inits, dones;

    pe_row_cfg_seq #(.NUM_PE(NUM_PE), .INST_W(INST_W), .RUN_W(RUN_W)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_mask(cfg_mask), .run_len(run_len),
        .run_stop(run_stop), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
        .PE_config(PE_config), .init_sel(init_sel), .init_en(init_en), .run(run),
        .busy(busy), .done(done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ready"}, cfg_ready, 0);
        check({tag, "_en"}, init_en, 0);
        check({tag, "_sel"}, init_sel, 0);
        check({tag, "_run"}, run, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_abort"}, aborted, 0);
    endtask

    task automatic run_until_done(input int max, output int r, output int n, output int d);
        r = 0; n = 0; d = 0;
        for (int i = 0; i < max; i++) begin
            if (run) r++;
            if (init_en) n++;
            if (done) begin
                d++;
                break;
            end
            tick;
        end
    endtask

    initial begin
        tick;
        tick;
        quiet("rst");
        check("rst_cfg", PE_config, 0);
        rst = 1'b1;
        tick;

        // 1: full mask, back-to-back words, run_len 3
        cfg_start = 1'b1; cfg_mask = 5'b11111; run_len = 3;
        tick;
        check("t1_busy", busy, 1);
        check("t1_ready", cfg_ready, 1);
        check("t1_noinit", init_en, 0);
        cfg_start = 1'b0; cfg_mask = '0; run_len = '0;
        cfg_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cfg_data = 32'hA0 + i;
            tick;
            check("t1_en", init_en, 1);
            check("t1_sel", init_sel, 32'h10 >> i);
            check("t1_cfg", PE_config, 32'hA0 + i);
            check("t1_norun", run, 0);
        end
        check("t1_gap_ready", cfg_ready, 0);
        cfg_valid = 1'b0;
        tick;
        check("t1_run1", run, 1);
        check("t1_run1_en", init_en, 0);
        check("t1_run1_sel", init_sel, 0);
        cfg_start = 1'b1; cfg_valid = 1'b1;
        tick;
        check("t1_run2", run, 1);
        cfg_start = 1'b0; cfg_valid = 1'b0;
        tick;
        check("t1_run3", run, 1);
        check("t1_run3_done", done, 0);
        tick;
        check("t1_end_run", run, 0);
        check("t1_done", done, 1);
        check("t1_done_busy", busy, 1);
        tick;
        quiet("t1_idle");
        tick;
        tick;
        quiet("t1_norestart");
        check("t1_cfg_hold", PE_config, 32'hA4);

        // 2: sparse mask, valid every other cycle
        cfg_start = 1'b1; cfg_mask = 5'b01010; run_len = 2;
        tick;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        tick;
        check("t2_wait_en", init_en, 0);
        cfg_valid = 1'b1; cfg_data = 32'h11;
        tick;
        check("t2_en0", init_en, 1);
        check("t2_sel0", init_sel, 5'b01000);
        check("t2_cfg0", PE_config, 32'h11);
        check("t2_ready0", cfg_ready, 1);
        cfg_valid = 1'b0; cfg_data = 32'h99;
        tick;
        check("t2_wait2_en", init_en, 0);
        check("t2_wait2_sel", init_sel, 0);
        check("t2_hold", PE_config, 32'h11);
        cfg_valid = 1'b1; cfg_data = 32'h22;
        tick;
        check("t2_en1", init_en, 1);
        check("t2_sel1", init_sel, 5'b00010);
        check("t2_cfg1", PE_config, 32'h22);
        check("t2_gap_ready", cfg_ready, 0);
        cfg_valid = 1'b0;
        tick;
        run_until_done(20, runs, inits, dones);
        check("t2_runs", runs, 2);
        check("t2_inits", inits, 0);
        check("t2_done", dones, 1);
        tick;
        quiet("t2_idle");

        // 3: empty mask, open-ended run stopped on 5th run cycle
        cfg_start = 1'b1; cfg_mask = '0; run_len = 0;
        tick;
        cfg_start = 1'b0;
        check("t3_busy", busy, 1);
        check("t3_ready", cfg_ready, 0);
        for (int i = 0; i < 4; i++) begin
            check("t3_run", run, 1);
            check("t3_en", init_en, 0);
            tick;
        end
        check("t3_run5", run, 1);
        run_stop = 1'b1;
        tick;
        run_stop = 1'b0;
        check("t3_stop_run", run, 0);
        check("t3_done", done, 1);
        tick;
        quiet("t3_idle");

        // 4: abort together with the 3rd transfer
        cfg_start = 1'b1; cfg_mask = 5'b11111; run_len = 4;
        tick;
        cfg_start = 1'b0;
        cfg_valid = 1'b1; cfg_data = 32'hB0;
        tick;
        check("t4_en0", init_en, 1);
        cfg_data = 32'hB1;
        tick;
        check("t4_en1", init_en, 1);
        check("t4_sel1", init_sel, 5'b01000);
        cfg_data = 32'hB2; run_stop = 1'b1;
        tick;
        run_stop = 1'b0; cfg_valid = 1'b0;
        check("t4_abort", aborted, 1);
        check("t4_drop_en", init_en, 0);
        check("t4_drop_sel", init_sel, 0);
        check("t4_cfg", PE_config, 32'hB1);
        check("t4_busy", busy, 0);
        check("t4_ready", cfg_ready, 0);
        check("t4_done", done, 0);
        runs = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (run || done || aborted) runs++;
        end
        check("t4_quiet_after", runs, 0);
        quiet("t4_idle");

        // 5: reset in the middle of a run
        cfg_start = 1'b1; cfg_mask = '0; run_len = 10;
        tick;
        check("t5_run", run, 1);
        cfg_start = 1'b1;
        tick;
        cfg_start = 1'b0;
        tick;
        check("t5_run3", run, 1);
        rst = 1'b0;
        tick;
        rst = 1'b1;
        quiet("t5_rst");
        check("t5_rst_cfg", PE_config, 0);
        tick;
        tick;
        quiet("t5_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
